// File: rtl/arp_pkg.sv
// arp_pkg: shared state encoding and broadcast constants for the ARP resolver
package arp_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        QUERY      = 3'd1,
        SEND_ARP   = 3'd2,
        WAIT_REPLY = 3'd3,
        RESPOND    = 3'd4
    } state_t;

    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam logic [31:0] BCAST_IP  = 32'hFFFF_FFFF;

endpackage

// File: rtl/arp_route_select.sv
// arp_route_select: picks next-hop IP (direct or gateway) and flags broadcast destinations
module arp_route_select
    import arp_pkg::*;
(
    input  logic [31:0] req_ip_i,
    input  logic [31:0] local_ip_i,
    input  logic [31:0] gateway_ip_i,
    input  logic [31:0] subnet_mask_i,
    output logic [31:0] target_ip_o,
    output logic        is_bcast_o
);

    logic on_subnet;

    assign on_subnet   = ((req_ip_i ^ local_ip_i) & subnet_mask_i) == 32'd0;
    assign target_ip_o = on_subnet ? req_ip_i : gateway_ip_i;
    assign is_bcast_o  = (req_ip_i == BCAST_IP) || (on_subnet && ((req_ip_i | subnet_mask_i) == BCAST_IP));

endmodule

// File: rtl/arp_resolver.sv
// arp_resolver: resolves an IP to a MAC via the ARP cache, issuing ARP requests with timeout/retry on a miss
module arp_resolver
    import arp_pkg::*;
#(
    parameter int RETRY_COUNT     = 4,
    parameter int REQUEST_TIMEOUT = 125000000,
    parameter int TIMER_WIDTH     = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_ip_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic        resp_error_o,
    output logic [47:0] resp_mac_o,
    output logic        cache_query_valid_o,
    output logic [31:0] cache_query_ip_o,
    input  logic        cache_resp_valid_i,
    output logic        cache_resp_ready_o,
    input  logic        cache_resp_error_i,
    input  logic [47:0] cache_resp_mac_i,
    input  logic        snoop_valid_i,
    input  logic [31:0] snoop_ip_i,
    input  logic [47:0] snoop_mac_i,
    output logic        arp_tx_valid_o,
    input  logic        arp_tx_ready_i,
    output logic [31:0] arp_tx_ip_o,
    input  logic [31:0] local_ip_i,
    input  logic [31:0] gateway_ip_i,
    input  logic [31:0] subnet_mask_i,
    output logic        busy_o
);

    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(REQUEST_TIMEOUT - 1);
    localparam logic [3:0]             RETRY_MAX  = 4'(RETRY_COUNT);

    state_t                 state_q, state_d;
    logic [31:0]            target_q, target_d;
    logic [47:0]            mac_q, mac_d;
    logic                   err_q, err_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [3:0]             retry_q, retry_d;
    logic [31:0]            route_ip;
    logic                   route_bcast;
    logic                   snoop_hit;

    arp_route_select u_route (
        .req_ip_i      (req_ip_i),
        .local_ip_i    (local_ip_i),
        .gateway_ip_i  (gateway_ip_i),
        .subnet_mask_i (subnet_mask_i),
        .target_ip_o   (route_ip),
        .is_bcast_o    (route_bcast)
    );

    assign snoop_hit        = snoop_valid_i && (snoop_ip_i == target_q);
    assign resp_mac_o       = mac_q;
    assign resp_error_o     = err_q;
    assign cache_query_ip_o = target_q;
    assign arp_tx_ip_o      = target_q;
    assign busy_o           = state_q != IDLE;

    // State and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            target_q <= '0;
            mac_q    <= '0;
            err_q    <= 1'b0;
            timer_q  <= '0;
            retry_q  <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            mac_q    <= mac_d;
            err_q    <= err_d;
            timer_q  <= timer_d;
            retry_q  <= retry_d;
        end
    end

    // Next-state and handshake outputs; a snoop hit wins over tx handshake and timeout
    always_comb begin
        state_d             = state_q;
        target_d            = target_q;
        mac_d               = mac_q;
        err_d               = err_q;
        timer_d             = timer_q;
        retry_d             = retry_q;
        req_ready_o         = (state_q == IDLE) && rst_n;
        cache_query_valid_o = state_q == QUERY;
        cache_resp_ready_o  = state_q == QUERY;
        arp_tx_valid_o      = (state_q == SEND_ARP) && !snoop_hit;
        resp_valid_o        = state_q == RESPOND;
        case (state_q)
            IDLE: if (req_valid_i) begin
                target_d = route_ip;
                mac_d    = BCAST_MAC;
                err_d    = 1'b0;
                state_d  = route_bcast ? RESPOND : QUERY;
            end
            QUERY: if (cache_resp_valid_i) begin
                mac_d   = cache_resp_mac_i;
                err_d   = 1'b0;
                retry_d = '0;
                state_d = cache_resp_error_i ? SEND_ARP : RESPOND;
            end
            SEND_ARP: if (snoop_hit) begin
                mac_d   = snoop_mac_i;
                err_d   = 1'b0;
                state_d = RESPOND;
            end else if (arp_tx_ready_i) begin
                retry_d = retry_q + 4'd1;
                timer_d = '0;
                state_d = WAIT_REPLY;
            end
            WAIT_REPLY: begin
                timer_d = (timer_q == '1) ? timer_q : timer_q + TIMER_WIDTH'(1);
                if (snoop_hit) begin
                    mac_d   = snoop_mac_i;
                    err_d   = 1'b0;
                    state_d = RESPOND;
                end else if (timer_q == TIMER_LAST) begin
                    err_d   = retry_q >= RETRY_MAX;
                    mac_d   = (retry_q >= RETRY_MAX) ? 48'd0 : mac_q;
                    state_d = (retry_q >= RETRY_MAX) ? RESPOND : SEND_ARP;
                end
            end
            RESPOND: if (resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_arp_resolver.sv
// tb_arp_resolver: directed and randomized resolve transactions against a behavioural routing/outcome model
module tb_arp_resolver;

    localparam int RC = 3;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [31:0] req_ip = '0;
    logic        resp_valid, resp_ready = 1'b0, resp_error;
    logic [47:0] resp_mac;
    logic        cache_query_valid, cache_resp_ready;
    logic [31:0] cache_query_ip;
    logic        cache_resp_valid = 1'b0, cache_resp_error = 1'b0;
    logic [47:0] cache_resp_mac = '0;
    logic        snoop_valid = 1'b0;
    logic [31:0] snoop_ip = '0;
    logic [47:0] snoop_mac = '0;
    logic        arp_tx_valid, arp_tx_ready = 1'b0;
    logic [31:0] arp_tx_ip;
    logic [31:0] local_ip = '0, gateway_ip = '0, subnet_mask = '0;
    logic        busy;

    int ncmp = 0;
    int nfail = 0;
    int plen = 24;

    int          hs_cnt = 0;
    int          since_hs = 0;
    bit          gap_arm = 1'b0;
    int          gaps[$];
    logic [31:0] hs_ips[$];

    always #5 clk = ~clk;

    arp_resolver #(.RETRY_COUNT(RC), .REQUEST_TIMEOUT(TO), .TIMER_WIDTH(32)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .req_valid_i         (req_valid),
        .req_ready_o         (req_ready),
        .req_ip_i            (req_ip),
        .resp_valid_o        (resp_valid),
        .resp_ready_i        (resp_ready),
        .resp_error_o        (resp_error),
        .resp_mac_o          (resp_mac),
        .cache_query_valid_o (cache_query_valid),
        .cache_query_ip_o    (cache_query_ip),
        .cache_resp_valid_i  (cache_resp_valid),
        .cache_resp_ready_o  (cache_resp_ready),
        .cache_resp_error_i  (cache_resp_error),
        .cache_resp_mac_i    (cache_resp_mac),
        .snoop_valid_i       (snoop_valid),
        .snoop_ip_i          (snoop_ip),
        .snoop_mac_i         (snoop_mac),
        .arp_tx_valid_o      (arp_tx_valid),
        .arp_tx_ready_i      (arp_tx_ready),
        .arp_tx_ip_o         (arp_tx_ip),
        .local_ip_i          (local_ip),
        .gateway_ip_i        (gateway_ip),
        .subnet_mask_i       (subnet_mask),
        .busy_o              (busy)
    );

    // ARP command monitor: counts handshakes, records target IPs and the gap to the next command
    always @(posedge clk) begin
        since_hs <= since_hs + 1;
        if (arp_tx_valid && gap_arm) begin
            gaps.push_back(since_hs + 1);
            gap_arm <= 1'b0;
        end
        if (arp_tx_valid && arp_tx_ready) begin
            hs_cnt <= hs_cnt + 1;
            hs_ips.push_back(arp_tx_ip);
            since_hs <= 0;
            gap_arm <= 1'b1;
        end
        if (resp_valid || !rst_n) gap_arm <= 1'b0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_net(input logic [31:0] loc, input logic [31:0] gw, input int p);
        plen = p;
        local_ip = loc;
        gateway_ip = gw;
        subnet_mask = ~((32'h1 << (32 - p)) - 32'h1);
    endtask

    // Routing model in prefix/host terms: same network prefix means direct delivery
    function automatic void model(input logic [31:0] ip, output logic [31:0] tgt, output bit bc);
        logic [31:0] host;
        bit on;
        host = (32'h1 << (32 - plen)) - 32'h1;
        on = (ip >> (32 - plen)) == (local_ip >> (32 - plen));
        tgt = on ? ip : gateway_ip;
        bc = (ip == 32'hFFFF_FFFF) || (on && ((ip & host) == host));
    endfunction

    // kind: 0 cache hit, 1 miss answered by snoop, 2 miss never answered
    task automatic do_req(input logic [31:0] ip, input int kind, input logic [47:0] mac,
                          input int snoop_at, input int hold);
        logic [31:0] tgt;
        bit bc;
        int exp_n, hs0, g0, i0, cyc, first_hs, qdelay, held, resp_cyc;
        bit queried, seen, done;
        logic [47:0] exp_mac, got_mac;
        logic exp_err, got_err;
        logic [63:0] r;
        model(ip, tgt, bc);
        exp_n   = bc ? 0 : (kind == 0 ? 0 : (kind == 1 ? 1 : RC));
        exp_mac = bc ? 48'hFFFF_FFFF_FFFF : (kind == 2 ? 48'd0 : mac);
        exp_err = !bc && kind == 2;
        hs0 = hs_cnt; g0 = gaps.size(); i0 = hs_ips.size();
        cyc = 0; first_hs = -1; qdelay = 0; held = 0; resp_cyc = -1;
        queried = 0; seen = 0; done = 0; got_mac = '0; got_err = 1'b0;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_ip = ip;
        @(negedge clk);
        req_valid = 1'b0;
        while (!done && cyc < 2000) begin
            cache_resp_valid = 1'b0;
            snoop_valid = 1'b0;
            r = {$urandom(), $urandom()};
            if (cache_query_valid) begin
                if (!queried) begin
                    chk("cache_query_ip", cache_query_ip, tgt);
                    queried = 1;
                    qdelay = $urandom_range(0, 3);
                end
                if (qdelay == 0) begin
                    cache_resp_valid = 1'b1;
                    cache_resp_error = kind != 0;
                    cache_resp_mac = (kind == 0) ? mac : r[47:0];
                end else qdelay--;
            end else if ($urandom_range(0, 15) == 0) begin
                cache_resp_valid = 1'b1;
                cache_resp_error = 1'b0;
                cache_resp_mac = r[47:0];
            end
            if (first_hs < 0 && hs_cnt > hs0) first_hs = cyc;
            if (kind == 1 && first_hs >= 0 && cyc - first_hs == snoop_at) begin
                snoop_valid = 1'b1;
                snoop_ip = tgt;
                snoop_mac = mac;
            end else if ($urandom_range(0, 7) == 0) begin
                snoop_valid = 1'b1;
                snoop_ip = tgt ^ (32'h1 << $urandom_range(0, 31));
                snoop_mac = r[47:0];
            end
            arp_tx_ready = 1'($urandom_range(0, 1));
            if (resp_valid) begin
                if (!seen) begin
                    seen = 1;
                    resp_cyc = cyc;
                    got_mac = resp_mac;
                    got_err = resp_error;
                end else chk("resp_hold", {resp_error, resp_mac}, {got_err, got_mac});
                if (held >= hold) resp_ready = 1'b1;
                else begin
                    resp_ready = 1'b0;
                    held++;
                end
            end else begin
                resp_ready = 1'b0;
                if (seen) done = 1;
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        cache_resp_valid = 1'b0;
        snoop_valid = 1'b0;
        arp_tx_ready = 1'b0;
        resp_ready = 1'b0;
        chk("resp_seen", done, 1);
        chk("resp_mac", got_mac, exp_mac);
        chk("resp_error", got_err, exp_err);
        chk("arp_cmd_count", hs_cnt - hs0, exp_n);
        chk("cache_queried", queried, !bc);
        if (bc) chk("bcast_latency", resp_cyc, 0);
        for (int i = i0; i < hs_ips.size(); i++) chk("arp_tx_ip", hs_ips[i], tgt);
        if (kind == 2 && !bc) chk("retry_gap_count", gaps.size() - g0, RC - 1);
        for (int i = g0; i < gaps.size(); i++) chk("retry_gap", gaps[i], TO + 1);
        chk("req_ready_after", req_ready, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, hs0, bad;
        logic [31:0] ip;
        logic [63:0] r;
        int kind;
        set_net(32'hC0A8_0164, 32'hC0A8_0101, 24);
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_valids", {resp_valid, cache_query_valid, arp_tx_valid, busy}, 0);
        chk("rst_resp", {resp_error, resp_mac}, 0);
        chk("rst_ips", {arp_tx_ip, cache_query_ip}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", req_ready, 1);

        do_req(32'hC0A8_0105, 0, 48'h0200_0000_0005, 0, 0);
        do_req(32'h0A00_0001, 1, 48'h0200_0000_0001, 30, 1);
        do_req(32'hC0A8_01FF, 0, 48'h0, 0, 3);
        do_req(32'hFFFF_FFFF, 2, 48'h0, 0, 0);
        do_req(32'hC0A8_0105, 1, 48'h0A0B_0C0D_0E0F, 50, 0);
        do_req(32'hC0A8_0107, 2, 48'h0, 0, 10);

        // abandon a request in WAIT_REPLY with a one-cycle reset
        @(negedge clk);
        req_valid = 1'b1;
        req_ip = 32'hC0A8_0109;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!cache_query_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        cache_resp_valid = 1'b1;
        cache_resp_error = 1'b1;
        @(negedge clk);
        cache_resp_valid = 1'b0;
        arp_tx_ready = 1'b1;
        hs0 = hs_cnt;
        k = 0;
        while (hs_cnt == hs0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        arp_tx_ready = 1'b0;
        chk("rst_arp_sent", hs_cnt - hs0, 1);
        repeat (20) @(negedge clk);
        chk("rst_busy_before", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_valids", {resp_valid, cache_query_valid, arp_tx_valid, busy}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", req_ready, 1);
        bad = 0;
        arp_tx_ready = 1'b1;
        repeat (150) begin
            if (resp_valid || arp_tx_valid || busy) bad++;
            @(negedge clk);
        end
        arp_tx_ready = 1'b0;
        chk("rst_no_response", bad, 0);

        for (int n = 0; n < 20; n++) begin
            set_net($urandom(), $urandom(), $urandom_range(8, 30));
            r = {$urandom(), $urandom()};
            case ($urandom_range(0, 4))
                0, 1:    ip = (local_ip & subnet_mask) | (r[31:0] & ~subnet_mask);
                2:       ip = r[63:32];
                3:       ip = local_ip | ~subnet_mask;
                default: ip = 32'hFFFF_FFFF;
            endcase
            kind = $urandom_range(0, 2);
            do_req(ip, kind, r[47:0], $urandom_range(1, 80), $urandom_range(0, 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
